// File: rtl/data_mem_pkg.sv
// Shared constants and FSM state type for the data RAM controller and its storage array.
package data_mem_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DEPTH    = 256;
  localparam int DEF_READ_LAT = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_t;

endpackage

// File: rtl/data_ram_array.sv
// Plain word storage: one synchronous write port, one registered read port, no reset.
module data_ram_array
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int IDX_W  = $clog2(DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read and write on the same edge: the read sees the old word.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/data_ram_ctrl.sv
// Data RAM controller: post-reset clear sweep, request decode, range check and read pipeline.
module data_ram_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int READ_LAT = DEF_READ_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              addr_err
);

  localparam int                IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ram_state_t        state;
  logic [ADDR_W-1:0] clr_addr;

  logic              in_range;
  logic              rd_acc;
  logic              wr_acc;

  logic              arr_we;
  logic [IDX_W-1:0]  arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic              arr_re;
  logic [DATA_W-1:0] arr_rdata;

  logic              rd_v1;
  logic              rd_err1;
  logic              wr_err1;
  logic [DATA_W-1:0] stage1_data;

  logic              out_v;
  logic              out_err;
  logic [DATA_W-1:0] out_d;
  logic [DATA_W-1:0] rdata_q;

  assign in_range = ({1'b0, addr} < DEPTH_X);
  assign rd_acc   = ~busy & mem_read;
  assign wr_acc   = ~busy & mem_write & in_range;

  // busy mirrors the CLEAR state but is kept as its own register so it is a clean flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else begin
      unique case (state)
        CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            state <= READY;
            busy  <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        READY: begin
          state <= READY;
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // The sweep owns the write port while busy; user writes only land in range.
  assign arr_we    = busy | wr_acc;
  assign arr_waddr = busy ? clr_addr[IDX_W-1:0] : addr[IDX_W-1:0];
  assign arr_wdata = busy ? '0 : wdata;
  assign arr_re    = rd_acc & in_range;

  data_ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (addr[IDX_W-1:0]),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v1   <= 1'b0;
      rd_err1 <= 1'b0;
      wr_err1 <= 1'b0;
    end else begin
      rd_v1   <= rd_acc;
      rd_err1 <= rd_acc & ~in_range;
      wr_err1 <= ~busy & mem_write & ~mem_read & ~in_range;
    end
  end

  assign stage1_data = rd_err1 ? '0 : arr_rdata;

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              v2;
      logic              err2;
      logic [DATA_W-1:0] d2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v2   <= 1'b0;
          err2 <= 1'b0;
          d2   <= '0;
        end else begin
          v2   <= rd_v1;
          err2 <= rd_err1;
          d2   <= stage1_data;
        end
      end

      assign out_v   = v2;
      assign out_err = err2;
      assign out_d   = d2;
    end else begin : g_lat1
      assign out_v   = rd_v1;
      assign out_err = rd_err1;
      assign out_d   = stage1_data;
    end
  endgenerate

  // Holding register keeps rdata stable between rvalid pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (out_v) begin
      rdata_q <= out_d;
    end
  end

  assign rdata    = out_v ? out_d : rdata_q;
  assign rvalid   = out_v;
  assign addr_err = (out_v & out_err) | wr_err1;

endmodule
